// File: rtl/fcb_pkg.sv
// Shared types and default geometry for the frame capture buffer.
package fcb_pkg;

    typedef enum logic {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } fcb_state_e;

    localparam int unsigned DEF_LINE_BITS     = 2640;
    localparam int unsigned DEF_HDR_BITS      = 240;
    localparam int unsigned DEF_PAYLOAD_BYTES = 300;
    localparam int unsigned DEF_FRAME_BYTES   = 30000;
    localparam int unsigned DEF_OUT_BYTES     = 4;

endpackage

// File: rtl/fcb_frame_store.sv
// Byte-addressed frame store: one line-wide write port, one word-wide combinational read port.
module fcb_frame_store #(
    parameter int unsigned FRAME_BYTES   = 30000,
    parameter int unsigned PAYLOAD_BYTES = 300,
    parameter int unsigned OUT_BYTES     = 4,
    localparam int unsigned IW           = $clog2(FRAME_BYTES)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [IW-1:0]                  waddr,
    input  logic [PAYLOAD_BYTES-1:0][7:0]  wdata,
    input  logic [IW-1:0]                  raddr,
    output logic [8*OUT_BYTES-1:0]         rdata
);

    logic [7:0] mem [FRAME_BYTES];

    // Contents are deliberately not reset; a new frame always overwrites before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
                mem[IW'(waddr + IW'(k))] <= wdata[k];
            end
        end
    end

    // Lowest address lands in the least significant byte.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < int'(OUT_BYTES); j++) begin
            rdata[8*j +: 8] = mem[IW'(raddr + IW'(j))];
        end
    end

endmodule

// File: rtl/frame_capture_buffer.sv
// Captures header-stripped line payloads into a frame store, then drains the frame as little-endian words.
module frame_capture_buffer
    import fcb_pkg::*;
#(
    parameter int unsigned LINE_BITS     = DEF_LINE_BITS,
    parameter int unsigned HDR_BITS      = DEF_HDR_BITS,
    parameter int unsigned PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
    parameter int unsigned FRAME_BYTES   = DEF_FRAME_BYTES,
    parameter int unsigned OUT_BYTES     = DEF_OUT_BYTES
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [0:LINE_BITS-1]                              line_data,
    input  logic                                              line_valid,
    output logic                                              line_ready,
    input  logic                                              frame_abort,
    output logic [8*OUT_BYTES-1:0]                            out_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic                                              out_last,
    output logic                                              frame_done,
    output logic [$clog2(FRAME_BYTES/PAYLOAD_BYTES+1)-1:0]    lines_stored
);

    localparam int unsigned AW = $clog2(FRAME_BYTES + 1);
    localparam int unsigned IW = $clog2(FRAME_BYTES);
    localparam int unsigned LW = $clog2(FRAME_BYTES / PAYLOAD_BYTES + 1);

    if (HDR_BITS + 8 * PAYLOAD_BYTES > LINE_BITS) begin : g_geometry_check
        $error("frame_capture_buffer: header plus payload exceeds LINE_BITS");
    end

    fcb_state_e                   state;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [PAYLOAD_BYTES-1:0][7:0] payload;
    logic                         accept;
    logic                         unused_line;

    // Header and trailing pad bits carry nothing this block needs.
    assign unused_line = ^line_data;

    // Bit 0 of the line is its MSB, so each payload byte reads MSB-first.
    always_comb begin
        payload = '0;
        for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
            payload[k] = line_data[int'(HDR_BITS) + 8*k +: 8];
        end
    end

    assign accept = rst_n && !frame_abort && (state == CAPTURE) && line_valid;

    fcb_frame_store #(
        .FRAME_BYTES   (FRAME_BYTES),
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .OUT_BYTES     (OUT_BYTES)
    ) u_store (
        .clk   (clk),
        .we    (accept),
        .waddr (IW'(wr_ptr)),
        .wdata (payload),
        .raddr (IW'(rd_ptr)),
        .rdata (out_data)
    );

    // Control FSM; abort outranks everything except reset and also suppresses frame_done.
    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (!rst_n || frame_abort) begin
            state        <= CAPTURE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lines_stored <= '0;
            line_ready   <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (line_valid) begin
                        wr_ptr       <= wr_ptr + AW'(PAYLOAD_BYTES);
                        lines_stored <= lines_stored + LW'(1);
                        if (wr_ptr == AW'(FRAME_BYTES - PAYLOAD_BYTES)) begin
                            state      <= DRAIN;
                            frame_done <= 1'b1;
                            line_ready <= 1'b0;
                            out_valid  <= 1'b1;
                            out_last   <= (FRAME_BYTES == OUT_BYTES);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state        <= CAPTURE;
                            wr_ptr       <= '0;
                            rd_ptr       <= '0;
                            lines_stored <= '0;
                            line_ready   <= 1'b1;
                            out_valid    <= 1'b0;
                            out_last     <= 1'b0;
                        end else begin
                            rd_ptr   <= rd_ptr + AW'(OUT_BYTES);
                            out_last <= (rd_ptr == AW'(FRAME_BYTES - 2*OUT_BYTES));
                        end
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Self-checking bench for frame_capture_buffer at default and reduced geometry.
module tb_frame_capture_buffer;

    localparam int LB = 2640;
    localparam int HB = 240;
    localparam int PB = 300;
    localparam int FB = 30000;
    localparam int OB = 4;
    localparam int NL = FB / PB;
    localparam int NW = FB / OB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [0:LB-1] line_data;
    logic          line_valid;
    logic          line_ready;
    logic          frame_abort;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic [6:0]    lines_stored;

    logic [0:63]   s_line_data;
    logic          s_line_valid;
    logic          s_line_ready;
    logic          s_frame_abort;
    logic [15:0]   s_out_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic          s_out_last;
    logic          s_frame_done;
    logic [1:0]    s_lines_stored;

    frame_capture_buffer #(
        .LINE_BITS(LB), .HDR_BITS(HB), .PAYLOAD_BYTES(PB), .FRAME_BYTES(FB), .OUT_BYTES(OB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_data(line_data), .line_valid(line_valid),
        .line_ready(line_ready), .frame_abort(frame_abort), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .lines_stored(lines_stored)
    );

    frame_capture_buffer #(
        .LINE_BITS(64), .HDR_BITS(16), .PAYLOAD_BYTES(4), .FRAME_BYTES(8), .OUT_BYTES(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .line_data(s_line_data), .line_valid(s_line_valid),
        .line_ready(s_line_ready), .frame_abort(s_frame_abort), .out_data(s_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last),
        .frame_done(s_frame_done), .lines_stored(s_lines_stored)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_mem [FB];
    logic [7:0] cur_pl  [PB];
    logic [7:0] hold_pl [PB];
    logic [15:0] s_words [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Random header and pad bits; payload bytes placed MSB-first after the header.
    task automatic drive_line();
        for (int i = 0; i < LB; i++) line_data[i] = 1'($urandom);
        for (int k = 0; k < PB; k++)
            for (int b = 0; b < 8; b++)
                line_data[HB + 8*k + b] = cur_pl[k][7-b];
    endtask

    task automatic send_lines(input int first, input int count, input bit rnd);
        for (int n = first; n < first + count; n++) begin
            check("cap_ready", 32'(line_ready), 1);
            check("cap_lines", 32'(lines_stored), 32'(n));
            check("cap_no_done", 32'(frame_done), 0);
            check("cap_no_valid", 32'(out_valid), 0);
            for (int k = 0; k < PB; k++) begin
                cur_pl[k] = rnd ? 8'($urandom) : 8'((n*PB + k) % 256);
                exp_mem[n*PB + k] = cur_pl[k];
            end
            drive_line();
            line_valid = 1'b1;
            tick();
        end
    endtask

    task automatic drain_frame(input bit frame_a, input bit hold);
        int w = 0;
        int cyc = 0;
        int stall = 0;
        logic [31:0] exp_w;
        check("done_pulse", 32'(frame_done), 1);
        check("drain_ready", 32'(line_ready), 0);
        check("drain_lines", 32'(lines_stored), 32'(NL));
        line_valid = hold;
        if (hold) begin
            cur_pl = hold_pl;
            drive_line();
        end
        while (w < NW && cyc < 40000) begin
            exp_w = {exp_mem[4*w+3], exp_mem[4*w+2], exp_mem[4*w+1], exp_mem[4*w]};
            check("out_valid", 32'(out_valid), 1);
            check("out_data", out_data, exp_w);
            check("out_last", 32'(out_last), 32'(w == NW - 1));
            check("drain_ready", 32'(line_ready), 0);
            check("drain_lines", 32'(lines_stored), 32'(NL));
            if (cyc > 0) check("done_once", 32'(frame_done), 0);
            if (frame_a && w == 0)      check("first_word", out_data, 32'h03020100);
            if (frame_a && w == 100)    check("stall_word", out_data, 32'h93929190);
            if (frame_a && w == NW - 1) check("last_word", out_data, 32'h2F2E2D2C);
            if (cyc == 0)                      out_ready = 1'b1;
            else if (w == 100 && stall < 5)    begin out_ready = 1'b0; stall++; end
            else                               out_ready = ($urandom_range(3) != 0);
            if (out_ready) w++;
            tick();
            cyc++;
        end
        check("word_count", 32'(w), 32'(NW));
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 0);
        check("post_last", 32'(out_last), 0);
        check("post_ready", 32'(line_ready), 1);
        check("post_lines", 32'(lines_stored), 0);
        if (hold) begin
            tick();
            check("held_accept", 32'(lines_stored), 1);
            line_valid = 1'b0;
            for (int k = 0; k < PB; k++) exp_mem[k] = hold_pl[k];
        end
    endtask

    initial begin
        rst_n = 1'b0;
        line_data = '0; line_valid = 1'b0; frame_abort = 1'b0; out_ready = 1'b0;
        s_line_data = '0; s_line_valid = 1'b0; s_frame_abort = 1'b0; s_out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", 32'(line_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_lines", 32'(lines_stored), 0);
        check("s_rst_ready", 32'(s_line_ready), 1);
        check("s_rst_valid", 32'(s_out_valid), 0);

        // Frame A: patterned payload, out_ready already high on the completing line.
        send_lines(0, NL - 1, 1'b0);
        out_ready = 1'b1;
        send_lines(NL - 1, 1, 1'b0);
        for (int k = 0; k < PB; k++) hold_pl[k] = 8'($urandom);
        drain_frame(1'b1, 1'b1);

        // Frame B aborted after 37 lines, abort also blocks the line presented with it.
        send_lines(1, 36, 1'b1);
        check("abort_pre_lines", 32'(lines_stored), 37);
        for (int k = 0; k < PB; k++) cur_pl[k] = 8'($urandom);
        drive_line();
        line_valid = 1'b1;
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        line_valid = 1'b0;
        check("abort_lines", 32'(lines_stored), 0);
        check("abort_done", 32'(frame_done), 0);
        check("abort_ready", 32'(line_ready), 1);
        tick();
        check("abort_no_done", 32'(frame_done), 0);

        // Frame C: random data, drained with random back-pressure.
        send_lines(0, NL, 1'b1);
        line_valid = 1'b0;
        drain_frame(1'b0, 1'b0);

        // Abort coinciding with the frame-completing line.
        send_lines(0, NL - 1, 1'b1);
        for (int k = 0; k < PB; k++) cur_pl[k] = 8'($urandom);
        drive_line();
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        line_valid = 1'b0;
        check("abort100_done", 32'(frame_done), 0);
        check("abort100_lines", 32'(lines_stored), 0);
        check("abort100_valid", 32'(out_valid), 0);

        // Reset coinciding with the frame-completing line.
        send_lines(0, NL - 1, 1'b1);
        for (int k = 0; k < PB; k++) cur_pl[k] = 8'($urandom);
        drive_line();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        line_valid = 1'b0;
        check("rst100_done", 32'(frame_done), 0);
        check("rst100_lines", 32'(lines_stored), 0);
        check("rst100_ready", 32'(line_ready), 1);
        check("rst100_valid", 32'(out_valid), 0);
        tick();
        check("rst100_no_done", 32'(frame_done), 0);

        // Reduced geometry instance.
        s_out_ready = 1'b1;
        s_line_data = 64'hAAAA_0102_0304_0000;
        s_line_valid = 1'b1;
        check("s_ready0", 32'(s_line_ready), 1);
        tick();
        check("s_lines1", 32'(s_lines_stored), 1);
        s_line_data = 64'hAAAA_0506_0708_0000;
        tick();
        s_line_valid = 1'b0;
        check("s_done", 32'(s_frame_done), 1);
        check("s_lines2", 32'(s_lines_stored), 2);
        for (int i = 0; i < 4; i++) begin
            check("s_valid", 32'(s_out_valid), 1);
            check("s_data", 32'(s_out_data), 32'(s_words[i]));
            check("s_last", 32'(s_out_last), 32'(i == 3));
            tick();
        end
        check("s_post_valid", 32'(s_out_valid), 0);
        check("s_post_ready", 32'(s_line_ready), 1);
        check("s_post_lines", 32'(s_lines_stored), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
